// File: rtl/sap1_control_sequencer.sv
//============================================================================
// Module      : sap1_control_sequencer
// Description : SAP-1 control sequencer. A one-hot six-state ring counter
//               (T1..T6) plus an opcode decoder that produces the control
//               word for PC, MAR, RAM, IR, accumulator, B register,
//               adder/subtractor and output register.
//
// Ports       : clk     - system clock, rising edge
//               reset   - synchronous reset, active-low
//               opcode  - IR upper nibble (LDA=0 ADD=1 SUB=2 OUT=E HLT=F)
//               tstate  - one-hot ring state, bit0=T1 .. bit5=T6
//               halt    - sticky halted flag, cleared only by reset
//               Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo
//                       - control word (n-prefixed signals are active-low)
//
// Config      : SAP1_SKIP_NOP_EN - when defined, instructions end right
//               after their last active state (LDA 5, OUT 4, NOP 3 clocks);
//               otherwise every instruction takes six clocks.
//
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module sap1_control_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  output logic [5:0] tstate,
  output logic       halt,
  output logic       Cp,
  output logic       Ep,
  output logic       nLm,
  output logic       nCE,
  output logic       nLi,
  output logic       nEi,
  output logic       nLa,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       nLb,
  output logic       nLo
);

  localparam logic [3:0] c_op_lda = 4'h0;
  localparam logic [3:0] c_op_add = 4'h1;
  localparam logic [3:0] c_op_sub = 4'h2;
  localparam logic [3:0] c_op_out = 4'hE;
  localparam logic [3:0] c_op_hlt = 4'hF;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_t;

  tstate_t r_state;
  tstate_t w_state_next;
  logic    r_halt;
  logic    w_halt_next;

`ifdef SAP1_SKIP_NOP_EN
  logic w_is_nop;
  assign w_is_nop = (opcode != c_op_lda) && (opcode != c_op_add) &&
                    (opcode != c_op_sub) && (opcode != c_op_out) &&
                    (opcode != c_op_hlt);
`endif

  // State register: reset dominates everything else.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= T1;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_halt  <= w_halt_next;
    end
  end

  // Next-state logic. Illegal (non-one-hot) codes fall into the default
  // branch and recover to T1 even when halted.
  always_comb begin
    w_state_next = r_state;
    w_halt_next  = r_halt;
    case (r_state)
      T1: if (!r_halt) w_state_next = T2;
      T2: if (!r_halt) w_state_next = T3;
      T3: begin
        if (!r_halt) begin
`ifdef SAP1_SKIP_NOP_EN
          w_state_next = w_is_nop ? T1 : T4;
`else
          w_state_next = T4;
`endif
        end
      end
      T4: begin
        if (!r_halt) begin
          if (opcode == c_op_hlt) begin
            // Freeze in T4; halt is sticky until reset.
            w_halt_next  = 1'b1;
            w_state_next = T4;
          end else begin
`ifdef SAP1_SKIP_NOP_EN
            w_state_next = (opcode == c_op_out) ? T1 : T5;
`else
            w_state_next = T5;
`endif
          end
        end
      end
      T5: begin
        if (!r_halt) begin
`ifdef SAP1_SKIP_NOP_EN
          w_state_next = (opcode == c_op_lda) ? T1 : T6;
`else
          w_state_next = T6;
`endif
        end
      end
      T6:      if (!r_halt) w_state_next = T1;
      default: w_state_next = T1;
    endcase
  end

  // Control word decode. Everything starts inactive; a halted machine
  // keeps it that way regardless of ring state.
  always_comb begin
    Cp  = 1'b0;
    Ep  = 1'b0;
    nLm = 1'b1;
    nCE = 1'b1;
    nLi = 1'b1;
    nEi = 1'b1;
    nLa = 1'b1;
    Ea  = 1'b0;
    Su  = 1'b0;
    Eu  = 1'b0;
    nLb = 1'b1;
    nLo = 1'b1;
    if (!r_halt) begin
      case (r_state)
        T1: begin
          Ep  = 1'b1;
          nLm = 1'b0;
        end
        T2: Cp = 1'b1;
        T3: begin
          nCE = 1'b0;
          nLi = 1'b0;
        end
        T4: begin
          if ((opcode == c_op_lda) || (opcode == c_op_add) ||
              (opcode == c_op_sub)) begin
            nEi = 1'b0;
            nLm = 1'b0;
          end else if (opcode == c_op_out) begin
            Ea  = 1'b1;
            nLo = 1'b0;
          end
        end
        T5: begin
          if (opcode == c_op_lda) begin
            nCE = 1'b0;
            nLa = 1'b0;
          end else if ((opcode == c_op_add) || (opcode == c_op_sub)) begin
            nCE = 1'b0;
            nLb = 1'b0;
          end
        end
        T6: begin
          if ((opcode == c_op_add) || (opcode == c_op_sub)) begin
            Eu  = 1'b1;
            nLa = 1'b0;
            Su  = (opcode == c_op_sub);
          end
        end
        default: ;
      endcase
    end
  end

  assign tstate = r_state;
  assign halt   = r_halt;

endmodule

`default_nettype wire

// File: tb/tb_sap1_control_sequencer.sv
//============================================================================
// Module      : tb_sap1_control_sequencer
// Description : Directed self-checking bench for sap1_control_sequencer.
//               The control word is packed as
//               {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}; an asserted
//               signal is the inactive word with that bit flipped.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_sap1_control_sequencer;

  localparam logic [11:0] c_inactive = 12'h3E3;
  localparam logic [11:0] c_m_cp  = 12'h800;
  localparam logic [11:0] c_m_ep  = 12'h400;
  localparam logic [11:0] c_m_nlm = 12'h200;
  localparam logic [11:0] c_m_nce = 12'h100;
  localparam logic [11:0] c_m_nli = 12'h080;
  localparam logic [11:0] c_m_nei = 12'h040;
  localparam logic [11:0] c_m_nla = 12'h020;
  localparam logic [11:0] c_m_ea  = 12'h010;
  localparam logic [11:0] c_m_su  = 12'h008;
  localparam logic [11:0] c_m_eu  = 12'h004;
  localparam logic [11:0] c_m_nlb = 12'h002;
  localparam logic [11:0] c_m_nlo = 12'h001;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic [5:0] tstate;
  logic       halt;
  logic       Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo;
  logic [11:0] w_cw;

  int n_checks = 0;
  int n_fail   = 0;

  sap1_control_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .tstate (tstate),
    .halt   (halt),
    .Cp     (Cp),
    .Ep     (Ep),
    .nLm    (nLm),
    .nCE    (nCE),
    .nLi    (nLi),
    .nEi    (nEi),
    .nLa    (nLa),
    .Ea     (Ea),
    .Su     (Su),
    .Eu     (Eu),
    .nLb    (nLb),
    .nLo    (nLo)
  );

  assign w_cw = {Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected control word for ring step s (1..6) and opcode op.
  function automatic logic [11:0] exp_cw(input int s, input logic [3:0] op);
    logic [11:0] m;
    m = 12'h000;
    case (s)
      1: m = c_m_ep | c_m_nlm;
      2: m = c_m_cp;
      3: m = c_m_nce | c_m_nli;
      4: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) m = c_m_nei | c_m_nlm;
        else if (op == 4'hE)                         m = c_m_ea | c_m_nlo;
      end
      5: begin
        if (op == 4'h0)                    m = c_m_nce | c_m_nla;
        else if (op == 4'h1 || op == 4'h2) m = c_m_nce | c_m_nlb;
      end
      6: begin
        if (op == 4'h1)      m = c_m_eu | c_m_nla;
        else if (op == 4'h2) m = c_m_su | c_m_eu | c_m_nla;
      end
      default: m = 12'h000;
    endcase
    return c_inactive ^ m;
  endfunction

  // Clocks per instruction.
  function automatic int instr_len(input logic [3:0] op);
`ifdef SAP1_SKIP_NOP_EN
    if (op == 4'h0) return 5;
    if (op == 4'hE) return 4;
    if (op == 4'h1 || op == 4'h2) return 6;
    return 3;
`else
    return 6;
`endif
  endfunction

  // Runs one full instruction starting from T1, checks every step and
  // the return to T1 afterwards.
  task automatic run_instr(input logic [3:0] op);
    logic [5:0] exp_t;
    opcode = op;
    for (int s = 1; s <= instr_len(op); s++) begin
      exp_t = 6'b000001 << (s - 1);
      check($sformatf("op%0h T%0d tstate", op, s), 32'(tstate), 32'(exp_t));
      check($sformatf("op%0h T%0d cw", op, s), 32'(w_cw), 32'(exp_cw(s, op)));
      check($sformatf("op%0h T%0d halt", op, s), 32'(halt), 32'd0);
      tick();
    end
    check($sformatf("op%0h end tstate", op), 32'(tstate), 32'h01);
  endtask

  initial begin
    reset  = 1'b0;
    opcode = 4'h0;
    repeat (2) tick();
    reset = 1'b1;

    // Reset state.
    check("reset tstate", 32'(tstate), 32'h01);
    check("reset halt", 32'(halt), 32'd0);
    check("reset cw", 32'(w_cw), 32'(c_inactive ^ (c_m_ep | c_m_nlm)));

    run_instr(4'h0);  // LDA
    run_instr(4'h1);  // ADD
    run_instr(4'h2);  // SUB
    run_instr(4'hE);  // OUT
    run_instr(4'h7);  // NOP

    // HLT: walk to T4, then freeze.
    opcode = 4'hF;
    for (int s = 1; s <= 4; s++) begin
      check($sformatf("hlt T%0d tstate", s), 32'(tstate),
            32'(6'b000001 << (s - 1)));
      check($sformatf("hlt T%0d cw", s), 32'(w_cw), 32'(exp_cw(s, 4'hF)));
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halted %0d halt", i), 32'(halt), 32'd1);
      check($sformatf("halted %0d tstate", i), 32'(tstate), 32'h08);
      check($sformatf("halted %0d cw", i), 32'(w_cw), 32'(c_inactive));
      // Opcode changes must not wake a halted machine.
      opcode = (i == 10) ? 4'h1 : opcode;
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("post-hlt reset tstate", 32'(tstate), 32'h01);
    check("post-hlt reset halt", 32'(halt), 32'd0);
    check("post-hlt reset cw", 32'(w_cw), 32'(c_inactive ^ (c_m_ep | c_m_nlm)));

    // Reset during T5 of ADD.
    opcode = 4'h1;
    repeat (4) tick();
    check("add T5 tstate", 32'(tstate), 32'h10);
    check("add T5 cw", 32'(w_cw), 32'(exp_cw(5, 4'h1)));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid reset tstate", 32'(tstate), 32'h01);
    check("mid reset nLb", 32'(nLb), 32'd1);
    check("mid reset cw", 32'(w_cw), 32'(c_inactive ^ (c_m_ep | c_m_nlm)));

    run_instr(4'h7);  // NOP after the aborted ADD
    run_instr(4'h2);  // SUB still runs normally afterwards

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
